// File: rtl/rgb_led_serialiser.sv
// WS2812-style single-wire serialiser: takes 24-bit {R,G,B} words over valid/ready,
// sends them G-R-B MSB first as pulse-width-coded bits, then holds the line low to latch.
module rgb_led_serialiser #(
    parameter int T0H    = 4,
    parameter int T1H    = 8,
    parameter int TBIT   = 12,
    parameter int TLATCH = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    input  logic        rgb_valid,
    output logic        rgb_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);
    localparam int CW = $clog2(TBIT);
    localparam int LW = $clog2(TLATCH + 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t        r_state;
    logic [23:0]   r_shift;
    logic [CW-1:0] r_cyc;
    logic [4:0]    r_bit;
    logic [LW-1:0] r_lcnt;
    logic          r_dout;
    logic          r_busy;
    logic          r_frame_done;

    logic          w_last_cyc;
    logic          w_last_bit;
    logic          w_word_end;
    logic          w_accept;
    logic [23:0]   w_grb;
    logic [CW-1:0] w_cyc_nxt;
    logic [CW-1:0] w_high;
    logic [LW-1:0] w_lcnt_nxt;

    assign w_last_cyc = (r_cyc == CW'(TBIT - 1));
    assign w_last_bit = (r_bit == 5'd23);
    assign w_word_end = (r_state == SEND) && w_last_cyc && w_last_bit;
    assign rgb_ready  = (r_state == IDLE) || w_word_end;
    assign w_accept   = rgb_valid && rgb_ready;
    assign w_grb      = {rgb[15:8], rgb[23:16], rgb[7:0]};
    assign w_cyc_nxt  = r_cyc + CW'(1);
    assign w_high     = r_shift[23] ? CW'(T1H) : CW'(T0H);
    assign w_lcnt_nxt = r_lcnt + LW'(1);

    assign dout       = r_dout;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    // dout is registered from the *next* cycle count so the pulse lines up with cyc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cyc        <= '0;
            r_bit        <= '0;
            r_lcnt       <= '0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_state <= SEND;
                r_shift <= w_grb;
                r_cyc   <= '0;
                r_bit   <= '0;
                r_dout  <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: ;
                    SEND: begin
                        if (w_last_cyc) begin
                            if (w_last_bit) begin
                                r_state      <= LATCH;
                                r_lcnt       <= '0;
                                r_dout       <= 1'b0;
                                r_frame_done <= (TLATCH == 1);
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_shift <= {r_shift[22:0], 1'b0};
                                r_cyc   <= '0;
                                r_dout  <= 1'b1;
                            end
                        end else begin
                            r_cyc  <= w_cyc_nxt;
                            r_dout <= (w_cyc_nxt < w_high);
                        end
                    end
                    LATCH: begin
                        if (r_lcnt == LW'(TLATCH - 1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_lcnt       <= w_lcnt_nxt;
                            r_frame_done <= (w_lcnt_nxt == LW'(TLATCH - 1));
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/rgb_led_serialiser.md
Name: rgb_led_serialiser

Overview:
- Downstream consumer of the RGB colour converter's 24-bit rgb word.
- Serialises each accepted rgb word onto a single-wire, WS2812-style pulse-width-coded line that drives an addressable RGB LED chain.
- Accepts words through a valid/ready handshake and chains consecutive words with no gap.
- Emits a low latch period once the stream ends.

Parameters:
- T0H, 4: high-time in clk cycles for a '0' bit.
- T1H, 8: high-time in clk cycles for a '1' bit.
- TBIT, 12: total clk cycles per bit. Legal values require 0 < T0H < T1H < TBIT.
- TLATCH, 50: clk cycles dout is held low after the last word of a frame.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rgb, input, 24: colour word; [23:16]=R, [15:8]=G, [7:0]=B.
- rgb_valid, input, 1: rgb holds a word to send.
- rgb_ready, output, 1: block accepts rgb this cycle.
- dout, output, 1: serial LED data line, registered.
- busy, output, 1: high in SEND and LATCH.
- frame_done, output, 1: one-cycle pulse at end of latch.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset, effective immediately including mid-word:
  - state=IDLE, dout=0, busy=0, frame_done=0, rgb_ready=1.
  - All counters and the shift register are cleared.
- States:
  - IDLE -> SEND on rgb_valid && rgb_ready.
  - SEND -> SEND (chain) or LATCH at the end of bit 23.
  - LATCH -> IDLE after TLATCH cycles.
- Acceptance:
  - Occurs on a rising edge with rgb_valid && rgb_ready.
  - The word is captured into a 24-bit shift register reordered as {G,R,B}.
  - Transmission is MSB first: G[7], ..., G[0], R[7], ..., B[0].
- Bit timing:
  - Each bit occupies exactly TBIT cycles, counted by a cycle counter 0..TBIT-1.
  - dout=1 while the counter is below the high-time (T1H if the bit is 1, else T0H); dout=0 otherwise.
  - A bit counter runs 0..23.
- Latency:
  - The first dout high cycle is the cycle immediately after acceptance.
  - One word takes exactly 24*TBIT cycles.
- rgb_ready rules:
  - High throughout IDLE.
  - High in the final cycle of bit 23 (bit=23, cyc=TBIT-1).
  - Low at all other times.
- Chaining: if a word is accepted in the final cycle of bit 23, the next cycle begins bit 0 of the new word. There is no idle cycle and no latch.
- Latch entry and timing:
  - If no word is accepted in that final cycle, go to LATCH with dout=0 for TLATCH cycles.
  - frame_done=1 in the last LATCH cycle only, then IDLE.
- Handshake discipline:
  - rgb_valid while rgb_ready=0 is ignored; the word is not consumed.
  - The source must hold rgb stable until acceptance.
  - Valid arriving during LATCH waits for IDLE; the latch is never shortened.
- busy is high from the cycle after acceptance until the last LATCH cycle inclusive.
- No input register beyond the capture shift register. No FIFO.

Test Plan:
1. Single word rgb=24'hFF0000, valid for one accept:
   - 8 pulses of 4 high/8 low, then 8 pulses of 8 high/4 low, then 8 pulses of 4 high/8 low.
   - 288 cycles total, then 50 low cycles.
   - frame_done pulses 338 cycles after acceptance; back in IDLE with rgb_ready=1.
2. Back-to-back words 24'h0000FF then 24'h00FF00, valid held high:
   - Second word accepted at cycle 287 after the first accept.
   - dout rises at cycle 288 with no gap; 576 data cycles total.
   - Exactly one frame_done.
3. Extremes:
   - 24'h000000 -> 24 pulses, each 4 high/8 low.
   - 24'hFFFFFF -> 24 pulses, each 8 high/4 low.
   - busy=1 throughout.
4. Valid during SEND mid-word (bit 5):
   - rgb_ready=0 and the word is not accepted until the final cycle of bit 23.
   - The first word's waveform is unchanged.
5. Reset mid-word at bit 10:
   - dout=0, busy=0, rgb_ready=1 asynchronously, before the next clk edge.
   - After release, a new word 24'h00FF00 transmits from bit 0 with correct timing.
6. Valid asserted in LATCH cycle 20:
   - Not accepted until IDLE, at cycle 51 after the latch starts.
   - Full 50-cycle low latch observed before the new word.
